// File: rtl/adder_fu_sched_pkg.sv
// Shared types for the adder_fu scheduler: lane modes, FSM states
// and the lane-mode legality check.
package adder_fu_sched_pkg;

    typedef enum logic [1:0] {
        MODE_4X16 = 2'd0,
        MODE_2X32 = 2'd1,
        MODE_1X64 = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        OFF,
        WAKE,
        IDLE,
        ARB,
        EXEC,
        RESP
    } state_t;

    function automatic logic is_legal_mode(input logic [1:0] m);
        return (m == MODE_4X16) || (m == MODE_2X32) || (m == MODE_1X64);
    endfunction

endpackage

// File: rtl/adder_fu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or
// after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDW-1:0]     grant_idx,
    output logic               any
);

    logic [IDW-1:0] j;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        j            = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[j]) begin
                any             = 1'b1;
                grant_idx       = j;
                grant_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_fu_scheduler.sv
// Time-shares one adder_fu between NUM_REQ requesters with
// round-robin grants, per-op lane mode and idle power gating.
module adder_fu_scheduler
    import adder_fu_sched_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_REQ     = 4,
    parameter int FU_LAT      = 1,
    parameter int IDLE_CYCLES = 8,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][1:0]             req_mode,
    input  logic [NUM_REQ-1:0][7:0][WIDTH-1:0]  req_operands,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [IDW-1:0]                      rsp_id,
    output logic [3:0][WIDTH-1:0]               rsp_data,
    output logic                                rsp_carry,
    output logic                                rsp_err,
    output logic [7:0][WIDTH-1:0]               fu_inputs,
    output logic [1:0]                          fu_config,
    output logic                                fu_on_off,
    input  logic [3:0][WIDTH-1:0]               fu_outputs,
    input  logic                                fu_carry,
    output logic                                busy,
    output logic [15:0]                         ops_done
);

    localparam int LW = $clog2(FU_LAT + 1);
    localparam int CW = $clog2(IDLE_CYCLES + 1);

    state_t               state;
    state_t               state_nxt;
    logic [IDW-1:0]       ptr;
    logic [LW-1:0]        lat_cnt;
    logic [CW-1:0]        idle_cnt;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_any;
    logic                 any_valid;
    logic                 lat_done;
    logic                 idle_done;
    logic [1:0]           win_mode;
    logic                 win_legal;
    logic [IDW-1:0]       ptr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req          (req_valid),
        .ptr          (ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    assign any_valid = |req_valid;
    assign lat_done  = (lat_cnt == LW'(FU_LAT - 1));
    assign idle_done = (idle_cnt == CW'(IDLE_CYCLES - 1));
    assign win_mode  = req_mode[grant_idx];
    assign win_legal = is_legal_mode(win_mode);
    assign ptr_nxt   = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

    assign req_ready = (state == ARB) ? grant_onehot : '0;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE) && (state != OFF);
    assign fu_on_off = (state != OFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= OFF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            OFF:  if (any_valid) state_nxt = WAKE;
            WAKE: state_nxt = ARB;
            IDLE: begin
                if (any_valid)      state_nxt = ARB;
                else if (idle_done) state_nxt = OFF;
            end
            ARB: begin
                if (!grant_any)     state_nxt = IDLE;
                else if (win_legal) state_nxt = EXEC;
                else                state_nxt = RESP;
            end
            EXEC: if (lat_done) state_nxt = RESP;
            RESP: begin
                if (rsp_ready) state_nxt = any_valid ? ARB : IDLE;
            end
            default: state_nxt = OFF;
        endcase
    end

    // Illegal-mode ops never touch the FU, so its inputs keep the last legal op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            lat_cnt   <= '0;
            idle_cnt  <= '0;
            fu_inputs <= '0;
            fu_config <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (state == IDLE && !any_valid && !idle_done)
                idle_cnt <= idle_cnt + CW'(1);
            else
                idle_cnt <= '0;
            if (state == ARB && grant_any) begin
                ptr       <= ptr_nxt;
                rsp_id    <= grant_idx;
                lat_cnt   <= '0;
                rsp_data  <= '0;
                rsp_carry <= 1'b0;
                rsp_err   <= !win_legal;
                if (win_legal) begin
                    fu_inputs <= req_operands[grant_idx];
                    fu_config <= win_mode;
                end
            end
            if (state == EXEC) begin
                lat_cnt <= lat_cnt + LW'(1);
                if (lat_done) begin
                    rsp_data  <= fu_outputs;
                    rsp_carry <= fu_carry;
                end
            end
            if (state == RESP && rsp_ready)
                ops_done <= ops_done + 16'd1;
        end
    end

endmodule
